// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receiver: frame FSM states,
// key-prefix byte values and the odd-parity check.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL = 8'hF0;

    // True when data plus parity bit carries an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Consumer-side bundle of the PS/2 receiver: byte stream handshake,
// error/overflow pulses and decoded key events.
interface ps2_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_err;
    logic       rx_overflow;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_strobe;

    modport master (
        output rx_data, rx_valid, rx_err, rx_overflow,
        output key_code, key_ext, key_release, key_strobe,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_err, rx_overflow,
        input  key_code, key_ext, key_release, key_strobe,
        output rx_ready
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// Synchronous first-word-fall-through byte FIFO, depth 2**FIFO_BITS.
// A push while full is accepted only when a pop happens in the same cycle.
module ps2_rx_fifo #(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty
);
    localparam int DEPTH = 1 << FIFO_BITS;

    logic [7:0]           mem_q [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_BITS:0]   count_q, count_d;
    logic                 do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = count_q[FIFO_BITS];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + {{FIFO_BITS{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{FIFO_BITS{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{(FIFO_BITS-1){1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{(FIFO_BITS-1){1'b0}}, 1'b1};
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise + glitch-filter the device clock, decode
// 11-bit frames, queue good bytes. Key decoding built with PS2_RX_KEYDECODE_EN.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing odd-parity result
// STOP   | checking stop bit, then push byte or flag error
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 100000,
    parameter int FIFO_BITS  = 3
) (
    input  logic     clk_sys,
    input  logic     reset_n,
    input  logic     ps2_clk,
    input  logic     ps2_data,
    ps2_rx_if.master rx_if
);
    localparam int             TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_f_q, clk_f_d;
    logic [3:0]      flt_cnt_q, flt_cnt_d;
    logic            fall, bit_in;
    ps2_state_e      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      sr_q, sr_d;
    logic            par_ok_q, par_ok_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            push, err_d, err_q, ovf_d, ovf_q;
    logic            full, empty, pop;
    logic [7:0]      dout;

    assign bit_in = data_sync_q[1];

    // clk_f only follows the synced clock after FILTER_LEN agreeing samples.
    always_comb begin
        clk_f_d   = clk_f_q;
        flt_cnt_d = '0;
        if (clk_sync_q[1] != clk_f_q) begin
            if (flt_cnt_q == 4'(FILTER_LEN - 1)) clk_f_d = clk_sync_q[1];
            else                                 flt_cnt_d = flt_cnt_q + 4'd1;
        end
    end

    assign fall = clk_f_q & ~clk_f_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_ok_d  = par_ok_q;
        to_cnt_d  = to_cnt_q;
        push      = 1'b0;
        err_d     = 1'b0;
        if (fall) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: if (!bit_in) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    sr_d = {bit_in, sr_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
                PARITY: begin
                    par_ok_d = odd_parity_ok(sr_q, bit_in);
                    state_d  = STOP;
                end
                STOP: begin
                    if (par_ok_q && bit_in) push  = 1'b1;
                    else                    err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    assign pop   = rx_if.rx_ready & ~empty;
    assign ovf_d = push & full & ~pop;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_f_q     <= 1'b1;
            flt_cnt_q   <= '0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_f_q     <= clk_f_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            par_ok_q    <= par_ok_d;
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
            ovf_q       <= ovf_d;
        end
    end

    ps2_rx_fifo #(.FIFO_BITS(FIFO_BITS)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push),
        .din     (sr_q),
        .full    (full),
        .pop     (pop),
        .dout    (dout),
        .empty   (empty)
    );

    assign rx_if.rx_data     = dout;
    assign rx_if.rx_valid    = ~empty;
    assign rx_if.rx_err      = err_q;
    assign rx_if.rx_overflow = ovf_q;

`ifdef PS2_RX_KEYDECODE_EN
    logic       ext_q, rel_q, kstrobe_q, kext_q, krel_q;
    logic [7:0] kcode_q;

    // Decode sees every completed byte, even one the full FIFO drops.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            kstrobe_q <= 1'b0;
            kcode_q   <= '0;
            kext_q    <= 1'b0;
            krel_q    <= 1'b0;
        end else begin
            kstrobe_q <= 1'b0;
            if (err_d) begin
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end else if (push) begin
                if (sr_q == PS2_PFX_EXT) begin
                    ext_q <= 1'b1;
                end else if (sr_q == PS2_PFX_REL) begin
                    rel_q <= 1'b1;
                end else begin
                    kstrobe_q <= 1'b1;
                    kcode_q   <= sr_q;
                    kext_q    <= ext_q;
                    krel_q    <= rel_q;
                    ext_q     <= 1'b0;
                    rel_q     <= 1'b0;
                end
            end
        end
    end

    assign rx_if.key_code    = kcode_q;
    assign rx_if.key_ext     = kext_q;
    assign rx_if.key_release = krel_q;
    assign rx_if.key_strobe  = kstrobe_q;
`else
    assign rx_if.key_code    = 8'h00;
    assign rx_if.key_ext     = 1'b0;
    assign rx_if.key_release = 1'b0;
    assign rx_if.key_strobe  = 1'b0;
`endif
endmodule
